// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared widths, board divisor constants and terminal-count helper for the divider bank
package clkdiv_pkg;
  localparam int CNT_W = 32;
  localparam int SHIFT_W = 2;
  localparam logic [31:0] DIV_MUX = 32'd8000000;
  localparam logic [31:0] DIV_PWM = 32'd6250;
  function automatic logic [63:0] tc_of(input logic [63:0] div, input logic [7:0] sh);
    return div >> sh;
  endfunction
endpackage

// File: rtl/clock_divider_bank_if.sv
// clock_divider_bank_if: divisor configuration bus with pending-commit status
interface clock_divider_bank_if import clkdiv_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = clkdiv_pkg::CNT_W
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [NUM_CH-1:0] cfg_pending;
  modport master(output cfg_we, cfg_ch, cfg_div, input cfg_pending);
  modport slave(input cfg_we, cfg_ch, cfg_div, output cfg_pending);
endinterface

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider with shadowed divisor committed only at wrap or sync
module clk_div_channel import clkdiv_pkg::*; #(
  parameter int CNT_W = clkdiv_pkg::CNT_W,
  parameter int SHIFT_W = clkdiv_pkg::SHIFT_W,
  parameter logic [CNT_W-1:0] RST_DIV = '0
) (
  input  logic fast_clock,
  input  logic rst_n,
  input  logic en,
  input  logic sync,
  input  logic we,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [CNT_W-1:0] wdata,
  output logic div_clk,
  output logic tick,
  output logic pending
);
  logic [CNT_W-1:0] cnt, active_div, shadow, next_div;
  logic wrap;
  // >= rather than == so a lowered tc wraps at once instead of running to 2^CNT_W
  assign wrap = en && 64'(cnt) >= tc_of(64'(active_div), 8'(shift));
  assign next_div = we ? wdata : shadow;
  always_ff @(posedge fast_clock or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      active_div <= RST_DIV;
      shadow <= RST_DIV;
      pending <= 1'b0;
      div_clk <= 1'b1;
      tick <= 1'b0;
    end else begin
      tick <= wrap && !sync;
      if (sync || wrap) begin
        cnt <= '0;
        div_clk <= sync | ~div_clk;
        active_div <= next_div;
        shadow <= next_div;
        pending <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(en);
        if (we) begin
          shadow <= wdata;
          pending <= 1'b1;
        end
      end
    end
endmodule

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: NUM_CH independent 50%-duty dividers with tick strobes and phase-align sync
module clock_divider_bank import clkdiv_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = clkdiv_pkg::CNT_W,
  parameter int SHIFT_W = clkdiv_pkg::SHIFT_W,
  parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_DIV = {DIV_MUX, DIV_PWM}
) (
  input  logic fast_clock,
  input  logic rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH*SHIFT_W-1:0] speed_up,
  input  logic sync,
  clock_divider_bank_if.slave cfg,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0] pending;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .CNT_W(CNT_W),
      .SHIFT_W(SHIFT_W),
      .RST_DIV(DEFAULT_DIV[i*CNT_W +: CNT_W])
    ) u_ch (
      .fast_clock(fast_clock),
      .rst_n(rst_n),
      .en(ch_en[i]),
      .sync(sync),
      .we(cfg.cfg_we && cfg.cfg_ch == CH_W'(i)),
      .shift(speed_up[i*SHIFT_W +: SHIFT_W]),
      .wdata(cfg.cfg_div),
      .div_clk(div_clk[i]),
      .tick(tick[i]),
      .pending(pending[i])
    );
  end
  assign cfg.cfg_pending = pending;
endmodule
